// File: rtl/scope_trigger_capture.sv
`timescale 1ns/1ps
// scope_trigger_capture: single-channel oscilloscope capture engine.
// Samples one of eight ADC channels every (decim+1) clocks into a circular
// buffer. It keeps PRE_TRIG samples ahead of a level/slope (or forced) trigger
// and fills the rest of the window after it. Reads are indexed relative to the
// oldest sample of the captured window.
//
// Ports:
//   clock, reset_n     - system clock, asynchronous active-low reset
//   data[7:0]          - per-channel 12-bit ADC results
//   ch_sel             - channel to capture
//   decim              - sample period minus one, in clocks
//   trig_level         - trigger threshold
//   trig_slope         - 0 = rising, 1 = falling
//   arm                - start-capture pulse (accepted in idle/done only)
//   force_trig         - unconditional trigger while waiting for trigger
//   busy/triggered/done- capture status
//   rd_addr            - logical read index, 0 = oldest sample in window
//   rd_data            - read data, one cycle after rd_addr
module scope_trigger_capture #(
  parameter int unsigned DEPTH    = 512,
  parameter int unsigned PRE_TRIG = 128
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [7:0][11:0]         data,
  input  logic [2:0]               ch_sel,
  input  logic [15:0]              decim,
  input  logic [11:0]              trig_level,
  input  logic                     trig_slope,
  input  logic                     arm,
  input  logic                     force_trig,
  output logic                     busy,
  output logic                     triggered,
  output logic                     done,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [11:0]              rd_data
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PreLast  = AW'(PRE_TRIG - 1);
  localparam logic [AW-1:0] PostLast = AW'(DEPTH - PRE_TRIG - 2);
  localparam logic [AW-1:0] PreOfs   = AW'(PRE_TRIG);

  typedef enum logic [2:0] {StIdle, StPre, StWaitTrig, StPost, StDone} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] wr_cnt_q, wr_cnt_d;
  logic [AW-1:0] trig_ptr_q, trig_ptr_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [11:0]   prev_q, prev_d;
  logic          triggered_q, triggered_d;

  logic [11:0]   mem [DEPTH];
  logic [11:0]   rd_data_q;
  logic [AW-1:0] rd_phys;
  logic [11:0]   cur;
  logic          capturing;
  logic          tick;
  logic          hit;
  logic          we;

  assign cur       = data[ch_sel];
  assign capturing = (state_q == StPre) || (state_q == StWaitTrig) || (state_q == StPost);
  // decim is compared live, so a change takes effect at the next compare.
  assign tick      = capturing && (cnt_q == decim);
  assign hit       = trig_slope ? ((prev_q > trig_level) && (cur <= trig_level))
                                : ((prev_q < trig_level) && (cur >= trig_level));

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    wr_cnt_d    = wr_cnt_q;
    trig_ptr_d  = trig_ptr_q;
    cnt_d       = cnt_q;
    prev_d      = prev_q;
    triggered_d = triggered_q;
    we          = 1'b0;

    if (capturing) begin
      cnt_d = tick ? 16'd0 : 16'(cnt_q + 16'd1);
    end

    // Every tick in a capture state writes one sample and advances the pointer.
    if (tick) begin
      we       = 1'b1;
      wr_ptr_d = wr_ptr_q + AW'(1);
      prev_d   = cur;
    end

    unique case (state_q)
      StIdle, StDone: begin
        if (arm) begin
          state_d     = StPre;
          wr_ptr_d    = '0;
          wr_cnt_d    = '0;
          cnt_d       = '0;
          triggered_d = 1'b0;
        end
      end
      StPre: begin
        if (tick) begin
          if (wr_cnt_q == PreLast) begin
            wr_cnt_d = '0;
            state_d  = StWaitTrig;
          end else begin
            wr_cnt_d = wr_cnt_q + AW'(1);
          end
        end
      end
      StWaitTrig: begin
        // Level crossing and force on the same tick collapse into one trigger.
        if (tick && (hit || force_trig)) begin
          trig_ptr_d  = wr_ptr_q;
          triggered_d = 1'b1;
          wr_cnt_d    = '0;
          state_d     = StPost;
        end
      end
      StPost: begin
        if (tick) begin
          if (wr_cnt_q == PostLast) begin
            state_d = StDone;
          end else begin
            wr_cnt_d = wr_cnt_q + AW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      wr_cnt_q    <= '0;
      trig_ptr_q  <= '0;
      cnt_q       <= '0;
      prev_q      <= '0;
      triggered_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      wr_cnt_q    <= wr_cnt_d;
      trig_ptr_q  <= trig_ptr_d;
      cnt_q       <= cnt_d;
      prev_q      <= prev_d;
      triggered_q <= triggered_d;
    end
  end

  // Buffer is not reset; write enable drops with state forced to idle in reset.
  always_ff @(posedge clock) begin
    if (we) begin
      mem[wr_ptr_q] <= cur;
    end
  end

  // Power-of-two depth makes the modulo a natural wrap of the AW-bit sum.
  assign rd_phys = trig_ptr_q - PreOfs + rd_addr;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= mem[rd_phys];
    end
  end

  assign rd_data   = rd_data_q;
  assign busy      = capturing;
  assign triggered = triggered_q;
  assign done      = (state_q == StDone);

endmodule

// File: tb/tb_scope_trigger_capture.sv
`timescale 1ns/1ps
// Self-checking bench for scope_trigger_capture (DEPTH=512, PRE_TRIG=128).
module tb_scope_trigger_capture;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic [7:0][11:0] data;
  logic [2:0]       ch_sel;
  logic [15:0]      decim;
  logic [11:0]      trig_level;
  logic             trig_slope;
  logic             arm;
  logic             force_trig;
  logic             busy;
  logic             triggered;
  logic             done;
  logic [8:0]       rd_addr;
  logic [11:0]      rd_data;

  int checks = 0;
  int failures = 0;

  scope_trigger_capture #(.DEPTH(512), .PRE_TRIG(128)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .data       (data),
    .ch_sel     (ch_sel),
    .decim      (decim),
    .trig_level (trig_level),
    .trig_slope (trig_slope),
    .arm        (arm),
    .force_trig (force_trig),
    .busy       (busy),
    .triggered  (triggered),
    .done       (done),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data)
  );

  always #10 clock = ~clock;

  typedef struct {
    string      name;
    logic [11:0] exp;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    int          grp;
    logic [8:0]  addr;
    logic [11:0] exp;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Drive a read address, queue the expectation, compare one cycle later.
  task automatic read_req(input logic [8:0] a, input logic [11:0] e);
    sb_t s;
    @(negedge clock);
    rd_addr = a;
    s.name = $sformatf("rd_addr_%0d", a);
    s.exp  = e;
    sb_q.push_back(s);
    @(negedge clock);
    s = sb_q.pop_front();
    check(s.name, {20'd0, rd_data}, {20'd0, s.exp});
  endtask

  task automatic do_reset();
    @(negedge clock);
    arm = 1'b0;
    force_trig = 1'b0;
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  // Ramp 0,1,2,... per tick on channel ch (decim=0), rising trigger at lvl.
  task automatic ramp_capture(input logic [2:0] ch, input logic [11:0] lvl,
                              output int trig_val);
    bit seen;
    ch_sel = ch;
    trig_level = lvl;
    trig_slope = 1'b0;
    decim = 16'd0;
    force_trig = 1'b0;
    data = '{default: 12'h5a5};
    @(negedge clock);
    arm = 1'b1;
    @(negedge clock);
    arm = 1'b0;
    data[ch] = 12'd0;
    check("ramp_busy_after_arm", {31'd0, busy}, 32'd1);
    seen = 1'b0;
    trig_val = -1;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(negedge clock);
      // data[ch] still holds the value sampled at the edge just taken.
      if (triggered && !seen) begin
        seen = 1'b1;
        trig_val = int'(data[ch]);
      end
      if (!done) data[ch] = data[ch] + 12'd1;
    end
    check("ramp_done", {31'd0, done}, 32'd1);
    check("ramp_busy_clear", {31'd0, busy}, 32'd0);
  endtask

  // Arm on edge 0 and time (in edges) triggered and done; optionally pulse
  // arm into the edge 300, which lands in POST.
  task automatic arm_and_time(input bit pulse_mid, output int t_trig, output int t_done);
    @(negedge clock);
    arm = 1'b1;
    @(posedge clock);
    #1 arm = 1'b0;
    check("timed_busy_after_arm", {31'd0, busy}, 32'd1);
    t_trig = -1;
    t_done = -1;
    for (int n = 1; n <= 3000; n++) begin
      @(posedge clock);
      #1;
      if (pulse_mid) arm = (n == 299);
      if (triggered && t_trig < 0) t_trig = n;
      if (done) begin
        t_done = n;
        break;
      end
    end
    arm = 1'b0;
  endtask

  initial begin
    int tv, tt, td;
    // {group, logical read index, expected sample}
    vecs.push_back('{1, 9'd0,   12'd72});
    vecs.push_back('{1, 9'd128, 12'd200});
    vecs.push_back('{1, 9'd511, 12'd583});
    vecs.push_back('{1, 9'd1,   12'd73});
    vecs.push_back('{1, 9'd127, 12'd199});
    vecs.push_back('{1, 9'd129, 12'd201});
    vecs.push_back('{1, 9'd439, 12'd511});
    vecs.push_back('{1, 9'd440, 12'd512});
    vecs.push_back('{2, 9'd0,   12'd172});
    vecs.push_back('{2, 9'd128, 12'd300});
    vecs.push_back('{2, 9'd511, 12'd683});

    data = '{default: 12'h000};
    ch_sel = 3'd0;
    decim = 16'd0;
    trig_level = 12'd0;
    trig_slope = 1'b0;
    arm = 1'b0;
    force_trig = 1'b0;
    rd_addr = '0;
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_triggered", {31'd0, triggered}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_rd_data", {20'd0, rd_data}, 32'd0);
    reset_n = 1'b1;

    // Ramp on ch3, rising at 200.
    ramp_capture(3'd3, 12'd200, tv);
    check("ramp_trig_value", tv, 200);
    foreach (vecs[i]) if (vecs[i].grp == 1) read_req(vecs[i].addr, vecs[i].exp);

    // Falling at 100; the crossing happens only during PRE, then flat 50.
    do_reset();
    ch_sel = 3'd3;
    decim = 16'd0;
    trig_level = 12'd100;
    trig_slope = 1'b1;
    data = '{default: 12'd50};
    data[3] = 12'd150;
    @(negedge clock);
    arm = 1'b1;
    @(negedge clock);
    arm = 1'b0;
    repeat (60) @(negedge clock);
    data[3] = 12'd50;
    repeat (400) @(negedge clock);
    check("fall_pre_busy", {31'd0, busy}, 32'd1);
    check("fall_pre_triggered", {31'd0, triggered}, 32'd0);
    check("fall_pre_done", {31'd0, done}, 32'd0);

    // Flat 0x800, force pulse while waiting for trigger.
    do_reset();
    trig_slope = 1'b0;
    trig_level = 12'h900;
    data = '{default: 12'h800};
    @(negedge clock);
    arm = 1'b1;
    @(negedge clock);
    arm = 1'b0;
    repeat (200) @(negedge clock);
    check("force_pre_triggered", {31'd0, triggered}, 32'd0);
    force_trig = 1'b1;
    @(negedge clock);
    force_trig = 1'b0;
    check("force_triggered", {31'd0, triggered}, 32'd1);
    for (int i = 0; i < 600 && !done; i++) @(negedge clock);
    check("force_done", {31'd0, done}, 32'd1);
    read_req(9'd128, 12'h800);
    read_req(9'd0, 12'h800);

    // decim=3 with force held: 512 writes every 4 clocks.
    do_reset();
    decim = 16'd3;
    force_trig = 1'b1;
    arm_and_time(1'b0, tt, td);
    check("decim3_trig_edge", tt, 516);
    check("decim3_done_edge", td, 2048);

    // decim=0, force held, arm pulsed in POST is ignored.
    do_reset();
    decim = 16'd0;
    force_trig = 1'b1;
    arm_and_time(1'b1, tt, td);
    check("post_arm_trig_edge", tt, 129);
    check("post_arm_done_edge", td, 512);
    force_trig = 1'b0;
    repeat (4) @(negedge clock);
    arm = 1'b1;
    @(negedge clock);
    arm = 1'b0;
    check("rearm_done", {31'd0, done}, 32'd0);
    check("rearm_busy", {31'd0, busy}, 32'd1);
    check("rearm_triggered", {31'd0, triggered}, 32'd0);

    // Reset in the middle of POST, then a fresh capture.
    force_trig = 1'b1;
    repeat (250) @(negedge clock);
    check("mid_post_triggered", {31'd0, triggered}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_triggered", {31'd0, triggered}, 32'd0);
    check("rst_mid_done", {31'd0, done}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    force_trig = 1'b0;
    ramp_capture(3'd5, 12'd300, tv);
    check("ramp2_trig_value", tv, 300);
    foreach (vecs[i]) if (vecs[i].grp == 2) read_req(vecs[i].addr, vecs[i].exp);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
